// File: rtl/lzd64_seq_ctrl.sv
// rtl/lzd64_seq_ctrl.sv - sequential 64-bit leading-zero controller sharing one 32-bit detector
// Optional feature macro: LZD_NORM_SHIFT_EN (adds SHIFT state, norm register and out_norm port)

module LZDthtwo (
    input  logic [31:0] a,
    output logic [4:0]  p,
    output logic        v
);

    // Priority encode the highest set bit into a leading-zero count
    always_comb begin
        v = |a;
        p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                p = 5'(31 - i);
            end
        end
    end

endmodule

module lzd64_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_lz,
    output logic        out_zero,
`ifdef LZD_NORM_SHIFT_EN
    output logic [63:0] out_norm,
`endif
    output logic        busy
);

`ifdef LZD_NORM_SHIFT_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_SHIFT, S_DONE} state_t;
    localparam state_t S_POST = S_SHIFT;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_DONE} state_t;
    localparam state_t S_POST = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [63:0] word_q, word_d;
    logic [6:0]  lz_q, lz_d;
    logic        zero_q, zero_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
`ifdef LZD_NORM_SHIFT_EN
    logic [63:0] norm_q, norm_d;
`endif

    logic [31:0] lzd_in;
    logic [4:0]  lzd_p;
    logic        lzd_v;

    // Detector sees the lower half only in LO; upper half otherwise
    assign lzd_in = (state_q == S_LO) ? word_q[31:0] : word_q[63:32];

    LZDthtwo u_lzd (
        .a (lzd_in),
        .p (lzd_p),
        .v (lzd_v)
    );

    // Next-state, datapath updates and registered-output targets
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lz_d    = lz_q;
        zero_d  = zero_q;
`ifdef LZD_NORM_SHIFT_EN
        norm_d  = norm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (lzd_v) begin
                    lz_d    = {2'b00, lzd_p};
                    zero_d  = 1'b0;
                    state_d = S_POST;
                end else begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (lzd_v) begin
                    lz_d   = 7'd32 + {2'b00, lzd_p};
                    zero_d = 1'b0;
                end else begin
                    lz_d   = 7'd64;
                    zero_d = 1'b1;
                end
                state_d = S_POST;
            end
`ifdef LZD_NORM_SHIFT_EN
            S_SHIFT: begin
                norm_d  = lz_q[6] ? 64'd0 : (word_q << lz_q[5:0]);
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= 64'd0;
            lz_q        <= 7'd0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LZD_NORM_SHIFT_EN
            norm_q      <= 64'd0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            lz_q        <= lz_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef LZD_NORM_SHIFT_EN
            norm_q      <= norm_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_lz    = lz_q;
    assign out_zero  = zero_q;
`ifdef LZD_NORM_SHIFT_EN
    assign out_norm  = norm_q;
`endif

endmodule

// File: tb/tb_lzd64_seq_ctrl.sv
// tb/tb_lzd64_seq_ctrl.sv - directed self-checking bench for lzd64_seq_ctrl
module tb_lzd64_seq_ctrl;

`ifdef LZD_NORM_SHIFT_EN
    localparam int HI_LAT  = 3;
    localparam int LO_LAT  = 4;
    localparam int SPACING = 4;
    localparam int N_ACC   = 4;
`else
    localparam int HI_LAT  = 2;
    localparam int LO_LAT  = 3;
    localparam int SPACING = 3;
    localparam int N_ACC   = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [6:0]  out_lz;
    logic        out_zero;
    logic        busy;
`ifdef LZD_NORM_SHIFT_EN
    logic [63:0] out_norm;
`endif

    int checks = 0;
    int errors = 0;

    lzd64_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lz    (out_lz),
        .out_zero  (out_zero),
`ifdef LZD_NORM_SHIFT_EN
        .out_norm  (out_norm),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] d, output int lat, output bit rdy_low);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        lat      = 1;
        rdy_low  = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_low = 1'b0;
            step();
            lat++;
        end
        if (in_ready) rdy_low = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  rdy_low;
        bit  stray;
        int  acc[$];
        int  done_cnt;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lz", out_lz, 0);
        chk("rst_zero", out_zero, 0);
`ifdef LZD_NORM_SHIFT_EN
        chk("rst_norm", out_norm, 0);
`endif
        rst = 1'b0;
        step();

        // upper-half hit
        out_ready = 1'b1;
        chk("t1_in_ready", in_ready, 1);
        push(64'h0000_1234_0000_0000, lat, rdy_low);
        chk("t1_latency", lat, HI_LAT);
        chk("t1_lz", out_lz, 19);
        chk("t1_zero", out_zero, 0);
        chk("t1_busy", busy, 1);
`ifdef LZD_NORM_SHIFT_EN
        chk("t1_norm", out_norm, 64'h91A0_0000_0000_0000);
`endif
        step();
        chk("t1_idle_ready", in_ready, 1);
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // lowest bit only
        push(64'h0000_0000_0000_0001, lat, rdy_low);
        chk("t2_latency", lat, LO_LAT);
        chk("t2_lz", out_lz, 63);
        chk("t2_zero", out_zero, 0);
`ifdef LZD_NORM_SHIFT_EN
        chk("t2_norm", out_norm, 64'h8000_0000_0000_0000);
`endif
        step();

        // zero operand
        push(64'd0, lat, rdy_low);
        chk("t3_latency", lat, LO_LAT);
        chk("t3_lz", out_lz, 64);
        chk("t3_zero", out_zero, 1);
        chk("t3_ready_low", rdy_low, 1);
`ifdef LZD_NORM_SHIFT_EN
        chk("t3_norm", out_norm, 0);
`endif
        step();
        chk("t3_ready_back", in_ready, 1);

        // all ones with a downstream stall
        out_ready = 1'b0;
        push(64'hFFFF_FFFF_FFFF_FFFF, lat, rdy_low);
        chk("t4_latency", lat, HI_LAT);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom} >> 1;
            step();
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_lz", out_lz, 0);
            chk("t4_stall_ready", in_ready, 0);
`ifdef LZD_NORM_SHIFT_EN
            chk("t4_stall_norm", out_norm, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t4_release_valid", out_valid, 0);
        chk("t4_release_ready", in_ready, 1);

        // reset while in LO
        in_valid = 1'b1;
        in_data  = 64'h0000_0000_00F0_0000;
        step();
        in_valid = 1'b0;
        step();
        chk("t5_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_lz", out_lz, 0);
        chk("t5_rst_zero", out_zero, 0);
`ifdef LZD_NORM_SHIFT_EN
        chk("t5_rst_norm", out_norm, 0);
`endif
        step();
        rst   = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) stray = 1'b1;
            step();
        end
        chk("t5_no_output", stray, 0);
        push(64'h4000_0000_0000_0000, lat, rdy_low);
        chk("t5_next_latency", lat, HI_LAT);
        chk("t5_next_lz", out_lz, 1);
`ifdef LZD_NORM_SHIFT_EN
        chk("t5_next_norm", out_norm, 64'h8000_0000_0000_0000);
`endif
        step();

        // back-to-back with in_valid held high
        in_valid  = 1'b1;
        in_data   = 64'h4000_0000_0000_0000;
        out_ready = 1'b1;
        done_cnt  = 0;
        for (int k = 0; k < 13; k++) begin
            if (in_ready) acc.push_back(k);
            if (out_valid) done_cnt++;
            step();
        end
        in_valid = 1'b0;
        chk("t6_accepts", acc.size(), N_ACC);
        chk("t6_completions", done_cnt, N_ACC - 1);
        for (int i = 1; i < acc.size(); i++) begin
            chk("t6_spacing", acc[i] - acc[i-1], SPACING);
        end
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk("t6_drained", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
